// File: rtl/audio_echo_mixer.sv
// rtl/audio_echo_mixer.sv - stereo echo/delay mixer between codec ADC and DAC streams
module audio_echo_mixer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] from_adc_left_channel_data,
  input  logic                  from_adc_left_channel_valid,
  output logic                  from_adc_left_channel_ready,
  input  logic [DATA_WIDTH-1:0] from_adc_right_channel_data,
  input  logic                  from_adc_right_channel_valid,
  output logic                  from_adc_right_channel_ready,
  output logic [DATA_WIDTH-1:0] to_dac_left_channel_data,
  output logic                  to_dac_left_channel_valid,
  input  logic                  to_dac_left_channel_ready,
  output logic [DATA_WIDTH-1:0] to_dac_right_channel_data,
  output logic                  to_dac_right_channel_valid,
  input  logic                  to_dac_right_channel_ready,
  input  logic                  echo_en,
  input  logic [ADDR_WIDTH-1:0] delay_len,
  input  logic [2:0]            gain_shift
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   FC_MAX  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    MIX  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  held_l_q, held_l_d;
  logic                  held_r_q, held_r_d;
  logic [DATA_WIDTH-1:0] x_l_q, x_l_d;
  logic [DATA_WIDTH-1:0] x_r_q, x_r_d;
  logic [ADDR_WIDTH-1:0] wp_q, wp_d;
  logic [ADDR_WIDTH:0]   fc_q, fc_d;
  logic                  echo_en_q, echo_en_d;
  logic [ADDR_WIDTH-1:0] delay_q, delay_d;
  logic [2:0]            gain_q, gain_d;
  logic [DATA_WIDTH-1:0] dac_l_q, dac_l_d;
  logic [DATA_WIDTH-1:0] dac_r_q, dac_r_d;
  logic                  val_l_q, val_l_d;
  logic                  val_r_q, val_r_d;
  logic                  rdy_l_q, rdy_l_d;
  logic                  rdy_r_q, rdy_r_d;

  // Delay line: one stereo frame per word, left in the upper half
  logic [2*DATA_WIDTH-1:0] mem [DEPTH];
  logic [2*DATA_WIDTH-1:0] rd_data_q;

  logic [ADDR_WIDTH-1:0]        rd_addr;
  logic [ADDR_WIDTH:0]          eff_delay;
  logic                         echo_ok;
  logic [3:0]                   shamt;
  logic signed [DATA_WIDTH-1:0] d_l, d_r;
  logic [DATA_WIDTH-1:0]        e_l, e_r;
  logic [DATA_WIDTH-1:0]        y_l, y_r;

  // Signed add at one extra bit, clamped back to the sample range
  function automatic logic [DATA_WIDTH-1:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] s;
    s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) begin
      sat_add = s[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end else begin
      sat_add = s[DATA_WIDTH-1:0];
    end
  endfunction

  // Echo datapath: mask delayed data until enough frames exist, attenuate, mix
  always_comb begin
    rd_addr   = wp_q - delay_len;
    eff_delay = {(delay_q == '0), delay_q};
    echo_ok   = (fc_q >= eff_delay);
    shamt     = {1'b0, gain_q} + 4'd1;
    d_l       = echo_ok ? rd_data_q[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
    d_r       = echo_ok ? rd_data_q[DATA_WIDTH-1:0] : '0;
    e_l       = d_l >>> shamt;
    e_r       = d_r >>> shamt;
    y_l       = echo_en_q ? sat_add(x_l_q, e_l) : x_l_q;
    y_r       = echo_en_q ? sat_add(x_r_q, e_r) : x_r_q;
  end

  // Frame sequencer next state: capture pair, read delay line, mix, present
  always_comb begin
    state_d   = state_q;
    held_l_d  = held_l_q;
    held_r_d  = held_r_q;
    x_l_d     = x_l_q;
    x_r_d     = x_r_q;
    wp_d      = wp_q;
    fc_d      = fc_q;
    echo_en_d = echo_en_q;
    delay_d   = delay_q;
    gain_d    = gain_q;
    dac_l_d   = dac_l_q;
    dac_r_d   = dac_r_q;
    val_l_d   = val_l_q;
    val_r_d   = val_r_q;
    case (state_q)
      IDLE: begin
        if (from_adc_left_channel_valid && rdy_l_q) begin
          x_l_d    = from_adc_left_channel_data;
          held_l_d = 1'b1;
        end
        if (from_adc_right_channel_valid && rdy_r_q) begin
          x_r_d    = from_adc_right_channel_data;
          held_r_d = 1'b1;
        end
        if (held_l_q && held_r_q) begin
          state_d = RD;
        end
      end
      RD: begin
        echo_en_d = echo_en;
        delay_d   = delay_len;
        gain_d    = gain_shift;
        state_d   = MIX;
      end
      MIX: begin
        dac_l_d  = y_l;
        dac_r_d  = y_r;
        val_l_d  = 1'b1;
        val_r_d  = 1'b1;
        held_l_d = 1'b0;
        held_r_d = 1'b0;
        state_d  = OUT;
      end
      OUT: begin
        if (to_dac_left_channel_ready) begin
          val_l_d = 1'b0;
        end
        if (to_dac_right_channel_ready) begin
          val_r_d = 1'b0;
        end
        if (!val_l_d && !val_r_d) begin
          wp_d    = wp_q + 1'b1;
          fc_d    = (fc_q == FC_MAX) ? fc_q : fc_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // ADC readies are registered from the next state so they are clean outputs
    rdy_l_d = (state_d == IDLE) && !held_l_d;
    rdy_r_d = (state_d == IDLE) && !held_r_d;
  end

  // Sequencer state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      held_l_q  <= 1'b0;
      held_r_q  <= 1'b0;
      x_l_q     <= '0;
      x_r_q     <= '0;
      wp_q      <= '0;
      fc_q      <= '0;
      echo_en_q <= 1'b0;
      delay_q   <= '0;
      gain_q    <= '0;
      dac_l_q   <= '0;
      dac_r_q   <= '0;
      val_l_q   <= 1'b0;
      val_r_q   <= 1'b0;
      rdy_l_q   <= 1'b0;
      rdy_r_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      held_l_q  <= held_l_d;
      held_r_q  <= held_r_d;
      x_l_q     <= x_l_d;
      x_r_q     <= x_r_d;
      wp_q      <= wp_d;
      fc_q      <= fc_d;
      echo_en_q <= echo_en_d;
      delay_q   <= delay_d;
      gain_q    <= gain_d;
      dac_l_q   <= dac_l_d;
      dac_r_q   <= dac_r_d;
      val_l_q   <= val_l_d;
      val_r_q   <= val_r_d;
      rdy_l_q   <= rdy_l_d;
      rdy_r_q   <= rdy_r_d;
    end
  end

  // Delay-line RAM: read in RD, write mixed frame back in MIX (contents never cleared)
  always_ff @(posedge clk) begin
    if (state_q == RD) begin
      rd_data_q <= mem[rd_addr];
    end
    if (state_q == MIX) begin
      mem[wp_q] <= {y_l, y_r};
    end
  end

  assign from_adc_left_channel_ready  = rdy_l_q;
  assign from_adc_right_channel_ready = rdy_r_q;
  assign to_dac_left_channel_data     = dac_l_q;
  assign to_dac_left_channel_valid    = val_l_q;
  assign to_dac_right_channel_data    = dac_r_q;
  assign to_dac_right_channel_valid   = val_r_q;

endmodule

// File: tb/tb_audio_echo_mixer.sv
// tb/tb_audio_echo_mixer.sv - directed self-checking bench for audio_echo_mixer
module tb_audio_echo_mixer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] adc_l_data, adc_r_data;
  logic        adc_l_valid, adc_r_valid;
  logic        adc_l_ready, adc_r_ready;
  logic [31:0] dac_l_data, dac_r_data;
  logic        dac_l_valid, dac_r_valid;
  logic        dac_l_ready, dac_r_ready;
  logic        echo_en;
  logic [11:0] delay_len;
  logic [2:0]  gain_shift;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  audio_echo_mixer #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
    .clk                          (clk),
    .reset                        (reset),
    .from_adc_left_channel_data   (adc_l_data),
    .from_adc_left_channel_valid  (adc_l_valid),
    .from_adc_left_channel_ready  (adc_l_ready),
    .from_adc_right_channel_data  (adc_r_data),
    .from_adc_right_channel_valid (adc_r_valid),
    .from_adc_right_channel_ready (adc_r_ready),
    .to_dac_left_channel_data     (dac_l_data),
    .to_dac_left_channel_valid    (dac_l_valid),
    .to_dac_left_channel_ready    (dac_l_ready),
    .to_dac_right_channel_data    (dac_r_data),
    .to_dac_right_channel_valid   (dac_r_valid),
    .to_dac_right_channel_ready   (dac_r_ready),
    .echo_en                      (echo_en),
    .delay_len                    (delay_len),
    .gain_shift                   (gain_shift)
  );

  task automatic do_reset();
    reset       = 1'b1;
    adc_l_valid = 1'b0;
    adc_r_valid = 1'b0;
    dac_l_ready = 1'b1;
    dac_r_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_adc(input logic [31:0] l, input logic [31:0] r);
    logic got_l, got_r, rl, rr;
    int n;
    got_l = 1'b0; got_r = 1'b0; n = 0;
    adc_l_data = l; adc_r_data = r;
    adc_l_valid = 1'b1; adc_r_valid = 1'b1;
    while (!(got_l && got_r) && n < 40) begin
      rl = adc_l_ready; rr = adc_r_ready;
      @(posedge clk); #1; n++;
      if (adc_l_valid && rl) begin got_l = 1'b1; adc_l_valid = 1'b0; end
      if (adc_r_valid && rr) begin got_r = 1'b1; adc_r_valid = 1'b0; end
    end
    tests++;
    if (!(got_l && got_r)) begin
      fails++;
      $display("FAIL adc_handshake_timeout got_l=%0b got_r=%0b exp 1 1", got_l, got_r);
      adc_l_valid = 1'b0; adc_r_valid = 1'b0;
    end
  endtask

  task automatic wait_dac(output int lat);
    lat = 0;
    while (!(dac_l_valid && dac_r_valid) && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    tests++;
    if (lat >= 20) begin
      fails++;
      $display("FAIL dac_valid_timeout got %0d cycles exp <20", lat);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    dac_l_ready = 1'b1; dac_r_ready = 1'b1;
    while ((dac_l_valid || dac_r_valid) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    tests++;
    if (n >= 20) begin
      fails++;
      $display("FAIL dac_drain_timeout got %0d cycles exp <20", n);
    end
  endtask

  task automatic do_frame(input logic [31:0] l, input logic [31:0] r,
                          output logic [31:0] ol, output logic [31:0] orr, output int lat);
    send_adc(l, r);
    wait_dac(lat);
    ol = dac_l_data; orr = dac_r_data;
    drain();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    adc_l_valid = 1'b0; adc_r_valid = 1'b0;
    dac_l_ready = 1'b1; dac_r_ready = 1'b1;
    @(posedge clk); #1;
    tests++; if (adc_l_ready !== 1'b0) begin fails++; $display("FAIL reset_l_ready got %b exp 0", adc_l_ready); end
    tests++; if (adc_r_ready !== 1'b0) begin fails++; $display("FAIL reset_r_ready got %b exp 0", adc_r_ready); end
    tests++; if (dac_l_valid !== 1'b0) begin fails++; $display("FAIL reset_l_valid got %b exp 0", dac_l_valid); end
    tests++; if (dac_r_valid !== 1'b0) begin fails++; $display("FAIL reset_r_valid got %b exp 0", dac_r_valid); end
    tests++; if (dac_l_data !== 32'h0) begin fails++; $display("FAIL reset_l_data got %h exp 0", dac_l_data); end
    tests++; if (dac_r_data !== 32'h0) begin fails++; $display("FAIL reset_r_data got %h exp 0", dac_r_data); end
    reset = 1'b0;
    @(posedge clk); #1;
    tests++; if (adc_l_ready !== 1'b1) begin fails++; $display("FAIL idle_l_ready got %b exp 1", adc_l_ready); end
    tests++; if (adc_r_ready !== 1'b1) begin fails++; $display("FAIL idle_r_ready got %b exp 1", adc_r_ready); end
  endtask

  task automatic test_passthrough();
    logic [31:0] ol, orr;
    int lat;
    do_reset();
    echo_en = 1'b0; delay_len = 12'd4; gain_shift = 3'd0;
    do_frame(32'h0000_1000, 32'hFFFF_F000, ol, orr, lat);
    tests++; if (ol !== 32'h0000_1000) begin fails++; $display("FAIL pass_l got %h exp 00001000", ol); end
    tests++; if (orr !== 32'hFFFF_F000) begin fails++; $display("FAIL pass_r got %h exp fffff000", orr); end
    tests++; if (lat !== 3) begin fails++; $display("FAIL pass_latency got %0d exp 3", lat); end
  endtask

  task automatic test_impulse();
    logic [31:0] ol, orr, inp;
    logic [31:0] exp_out [9];
    int lat;
    exp_out = '{32'h4000_0000, 32'h0, 32'h0, 32'h0, 32'h2000_0000,
                32'h0, 32'h0, 32'h0, 32'h1000_0000};
    do_reset();
    echo_en = 1'b1; delay_len = 12'd4; gain_shift = 3'd0;
    for (int f = 0; f < 9; f++) begin
      inp = (f == 0) ? 32'h4000_0000 : 32'h0;
      do_frame(inp, inp, ol, orr, lat);
      tests++; if (ol !== exp_out[f]) begin fails++; $display("FAIL impulse_l frame %0d got %h exp %h", f, ol, exp_out[f]); end
      tests++; if (orr !== exp_out[f]) begin fails++; $display("FAIL impulse_r frame %0d got %h exp %h", f, orr, exp_out[f]); end
    end
  endtask

  task automatic test_saturation();
    logic [31:0] ol, orr;
    int lat;
    do_reset();
    echo_en = 1'b1; delay_len = 12'd1; gain_shift = 3'd0;
    do_frame(32'h7FFF_FFF0, 32'h7FFF_FFF0, ol, orr, lat);
    tests++; if (ol !== 32'h7FFF_FFF0) begin fails++; $display("FAIL satpos_f0 got %h exp 7ffffff0", ol); end
    do_frame(32'h7FFF_FFF0, 32'h7FFF_FFF0, ol, orr, lat);
    tests++; if (ol !== 32'h7FFF_FFFF) begin fails++; $display("FAIL satpos_l got %h exp 7fffffff", ol); end
    tests++; if (orr !== 32'h7FFF_FFFF) begin fails++; $display("FAIL satpos_r got %h exp 7fffffff", orr); end
    do_reset();
    do_frame(32'h8000_0010, 32'h8000_0010, ol, orr, lat);
    tests++; if (ol !== 32'h8000_0010) begin fails++; $display("FAIL satneg_f0 got %h exp 80000010", ol); end
    do_frame(32'h8000_0010, 32'h8000_0010, ol, orr, lat);
    tests++; if (ol !== 32'h8000_0000) begin fails++; $display("FAIL satneg_l got %h exp 80000000", ol); end
    tests++; if (orr !== 32'h8000_0000) begin fails++; $display("FAIL satneg_r got %h exp 80000000", orr); end
  endtask

  task automatic test_gain_and_channels();
    logic [31:0] ol, orr;
    int lat;
    do_reset();
    echo_en = 1'b1; delay_len = 12'd1; gain_shift = 3'd2;
    do_frame(32'h4000_0000, 32'hC000_0000, ol, orr, lat);
    do_frame(32'h0, 32'h0, ol, orr, lat);
    tests++; if (ol !== 32'h0800_0000) begin fails++; $display("FAIL gain_l got %h exp 08000000", ol); end
    tests++; if (orr !== 32'hF800_0000) begin fails++; $display("FAIL gain_r got %h exp f8000000", orr); end
    delay_len = 12'd0;
    do_frame(32'h0123_4567, 32'h89AB_CDEF, ol, orr, lat);
    tests++; if (ol !== 32'h0123_4567) begin fails++; $display("FAIL delay0_l got %h exp 01234567", ol); end
    tests++; if (orr !== 32'h89AB_CDEF) begin fails++; $display("FAIL delay0_r got %h exp 89abcdef", orr); end
  endtask

  task automatic test_out_of_order();
    int lat;
    do_reset();
    echo_en = 1'b0;
    adc_r_data = 32'h2222_2222; adc_r_valid = 1'b1;
    @(posedge clk); #1;
    adc_r_valid = 1'b0;
    tests++; if (adc_r_ready !== 1'b0) begin fails++; $display("FAIL ooo_r_ready got %b exp 0", adc_r_ready); end
    tests++; if (adc_l_ready !== 1'b1) begin fails++; $display("FAIL ooo_l_ready got %b exp 1", adc_l_ready); end
    repeat (4) @(posedge clk);
    #1;
    tests++; if (adc_r_ready !== 1'b0) begin fails++; $display("FAIL ooo_r_still got %b exp 0", adc_r_ready); end
    tests++; if (dac_l_valid !== 1'b0) begin fails++; $display("FAIL ooo_early_valid got %b exp 0", dac_l_valid); end
    adc_l_data = 32'h1111_1111; adc_l_valid = 1'b1;
    @(posedge clk); #1;
    adc_l_valid = 1'b0;
    wait_dac(lat);
    tests++; if (lat !== 3) begin fails++; $display("FAIL ooo_latency got %0d exp 3", lat); end
    tests++; if (dac_l_data !== 32'h1111_1111) begin fails++; $display("FAIL ooo_l got %h exp 11111111", dac_l_data); end
    tests++; if (dac_r_data !== 32'h2222_2222) begin fails++; $display("FAIL ooo_r got %h exp 22222222", dac_r_data); end
    drain();
  endtask

  task automatic test_backpressure();
    int lat;
    do_reset();
    echo_en = 1'b0;
    dac_l_ready = 1'b1; dac_r_ready = 1'b0;
    send_adc(32'hAAAA_0001, 32'h5555_0002);
    wait_dac(lat);
    @(posedge clk); #1;
    tests++; if (dac_l_valid !== 1'b0) begin fails++; $display("FAIL bp_l_drop got %b exp 0", dac_l_valid); end
    for (int i = 0; i < 9; i++) begin
      tests++; if (dac_r_valid !== 1'b1) begin fails++; $display("FAIL bp_r_hold cyc %0d got %b exp 1", i, dac_r_valid); end
      tests++; if (dac_r_data !== 32'h5555_0002) begin fails++; $display("FAIL bp_r_data cyc %0d got %h exp 55550002", i, dac_r_data); end
      tests++; if ((adc_l_ready | adc_r_ready) !== 1'b0) begin fails++; $display("FAIL bp_adc_ready cyc %0d got %b exp 0", i, adc_l_ready | adc_r_ready); end
      @(posedge clk); #1;
    end
    dac_r_ready = 1'b1;
    @(posedge clk); #1;
    tests++; if (dac_r_valid !== 1'b0) begin fails++; $display("FAIL bp_r_done got %b exp 0", dac_r_valid); end
    tests++; if (adc_l_ready !== 1'b1) begin fails++; $display("FAIL bp_next_ready got %b exp 1", adc_l_ready); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ol, orr;
    int lat;
    do_reset();
    echo_en = 1'b1; delay_len = 12'd1; gain_shift = 3'd0;
    do_frame(32'h1000_0000, 32'h1000_0000, ol, orr, lat);
    dac_l_ready = 1'b0; dac_r_ready = 1'b0;
    send_adc(32'h1000_0000, 32'h1000_0000);
    wait_dac(lat);
    tests++; if (dac_l_data !== 32'h1800_0000) begin fails++; $display("FAIL mid_echo got %h exp 18000000", dac_l_data); end
    reset = 1'b1;
    @(posedge clk); #1;
    tests++; if ((dac_l_valid | dac_r_valid) !== 1'b0) begin fails++; $display("FAIL mid_valid got %b exp 0", dac_l_valid | dac_r_valid); end
    tests++; if ((adc_l_ready | adc_r_ready) !== 1'b0) begin fails++; $display("FAIL mid_ready got %b exp 0", adc_l_ready | adc_r_ready); end
    reset = 1'b0;
    @(posedge clk); #1;
    do_frame(32'h3000_0000, 32'h5000_0000, ol, orr, lat);
    tests++; if (ol !== 32'h3000_0000) begin fails++; $display("FAIL mid_masked_l got %h exp 30000000", ol); end
    tests++; if (orr !== 32'h5000_0000) begin fails++; $display("FAIL mid_masked_r got %h exp 50000000", orr); end
  endtask

  initial begin
    reset = 1'b1;
    adc_l_data = '0; adc_r_data = '0;
    adc_l_valid = 1'b0; adc_r_valid = 1'b0;
    dac_l_ready = 1'b1; dac_r_ready = 1'b1;
    echo_en = 1'b0; delay_len = '0; gain_shift = '0;
    #1;
    test_reset();
    test_passthrough();
    test_impulse();
    test_saturation();
    test_gain_and_channels();
    test_out_of_order();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
